hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 36 +++
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bundle: stage hazard inputs toward the controller, register controls back.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  logic             MemRead_ex;
  logic [4:0]       rdAddr_ex;
  logic [4:0]       rs1Addr_id;
  logic [4:0]       rs2Addr_id;
  logic             rs1Used_id;
  logic             rs2Used_id;
  logic             BranchTaken_ex;
  logic             MemAccess_mem;
  logic             MemReady_mem;
  logic             PCWrite;
  logic             IFID_Write;
  logic             IFID_Flush;
  logic             IDEX_Stall;
  logic             IDEX_Hold;
  logic             EXMEM_Hold;
  logic             MEMWB_Bubble;
  logic             MemErr;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;

  modport master (
    output MemRead_ex, rdAddr_ex, rs1Addr_id, rs2Addr_id, rs1Used_id, rs2Used_id,
           BranchTaken_ex, MemAccess_mem, MemReady_mem,
    input  PCWrite, IFID_Write, IFID_Flush, IDEX_Stall, IDEX_Hold, EXMEM_Hold,
           MEMWB_Bubble, MemErr, StallCnt, FlushCnt
  );

  modport slave (
    input  MemRead_ex, rdAddr_ex, rs1Addr_id, rs2Addr_id, rs1Used_id, rs2Used_id,
           BranchTaken_ex, MemAccess_mem, MemReady_mem,
    output PCWrite, IFID_Write, IFID_Flush, IDEX_Stall, IDEX_Hold, EXMEM_Hold,
           MEMWB_Bubble, MemErr, StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, data-memory wait freeze with timeout.
// Optional performance counters enabled by macro HAZARD_PERF_CNT_EN.
//
// state | meaning
// RUN   | pipeline flowing; a not-ready memory access freezes it this cycle
// MWAIT | data memory not ready for consecutive cycles; counting toward timeout
// ERR   | memory timeout; pipeline frozen until reset
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, MWAIT, ERR} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       hit, mem_wait, freeze;
  logic       pc_write, ifid_write, ifid_flush, idex_stall;
  logic       idex_hold, exmem_hold, memwb_bubble;

  assign hit = bus.MemRead_ex && (bus.rdAddr_ex != 5'd0) &&
               ((bus.rs1Used_id && (bus.rs1Addr_id == bus.rdAddr_ex)) ||
                (bus.rs2Used_id && (bus.rs2Addr_id == bus.rdAddr_ex)));

  assign mem_wait = bus.MemAccess_mem && !bus.MemReady_mem;
  assign freeze   = (state == ERR) || mem_wait;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (mem_wait) begin
          state_nxt    = MWAIT;
          wait_cnt_nxt = 8'd1;
        end
      end
      MWAIT: begin
        if (!mem_wait) begin
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
        end else begin
          // the incremented count is the number of not-ready cycles ending at this edge
          wait_cnt_nxt = wait_cnt + 8'd1;
          if (wait_cnt + 8'd1 == TIMEOUT_C) state_nxt = ERR;
        end
      end
      ERR: state_nxt = ERR;
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_stall   = 1'b0;
    idex_hold    = 1'b0;
    exmem_hold   = 1'b0;
    memwb_bubble = 1'b0;
    if (freeze) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_hold    = 1'b1;
      exmem_hold   = 1'b1;
      memwb_bubble = 1'b1;
    end else if (bus.BranchTaken_ex) begin
      ifid_flush = 1'b1;
      idex_stall = 1'b1;
    end else if (hit) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_stall = 1'b1;
    end
  end

  assign bus.PCWrite      = pc_write;
  assign bus.IFID_Write   = ifid_write;
  assign bus.IFID_Flush   = ifid_flush;
  assign bus.IDEX_Stall   = idex_stall;
  assign bus.IDEX_Hold    = idex_hold;
  assign bus.EXMEM_Hold   = exmem_hold;
  assign bus.MEMWB_Bubble = memwb_bubble;
  assign bus.MemErr       = (state == ERR);

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // both counters saturate at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (ifid_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.StallCnt = stall_cnt;
  assign bus.FlushCnt = flush_cnt;
`else
  assign bus.StallCnt = '0;
  assign bus.FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then randomized traffic against a behavioural model.
module tb_hazard_ctrl;
  localparam int TO   = 15;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  bit   m_err;
  int   m_consec;
  int   m_stall;
  int   m_flush;

  hazard_ctrl_if #(.CNT_W(CW)) bus();
  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // expected {PCWrite, IFID_Write, IFID_Flush, IDEX_Stall, IDEX_Hold, EXMEM_Hold, MEMWB_Bubble, MemErr}
  function automatic logic [7:0] exp_ctrl();
    bit w, h;
    w = bus.MemAccess_mem && !bus.MemReady_mem;
    h = bus.MemRead_ex && (bus.rdAddr_ex != 0) &&
        ((bus.rs1Used_id && bus.rs1Addr_id == bus.rdAddr_ex) ||
         (bus.rs2Used_id && bus.rs2Addr_id == bus.rdAddr_ex));
    if (m_err || w)            return {7'b0000111, m_err};
    else if (bus.BranchTaken_ex) return {7'b1111000, m_err};
    else if (h)                return {7'b0001000, m_err};
    else                       return {7'b1100000, m_err};
  endfunction

  task automatic model_reset();
    m_err = 1'b0; m_consec = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic check_now(input string tag);
    logic [7:0]      obs, expv;
    logic [2*CW-1:0] cobs, cexp;
    obs  = {bus.PCWrite, bus.IFID_Write, bus.IFID_Flush, bus.IDEX_Stall,
            bus.IDEX_Hold, bus.EXMEM_Hold, bus.MEMWB_Bubble, bus.MemErr};
    expv = exp_ctrl();
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s ctrl observed=%b expected=%b", tag, obs, expv);
    end
    cobs = {bus.StallCnt, bus.FlushCnt};
    cexp = PERF ? {CW'(m_stall), CW'(m_flush)} : '0;
    tests++;
    assert (cobs === cexp) else begin
      fails++;
      $error("FAIL %s counters observed=%h expected=%h", tag, cobs, cexp);
    end
  endtask

  task automatic model_edge();
    logic [7:0] e;
    bit w;
    if (reset) return;
    e = exp_ctrl();
    w = bus.MemAccess_mem && !bus.MemReady_mem;
    m_consec = w ? m_consec + 1 : 0;
    if (m_consec == TO) m_err = 1'b1;
    if (!e[7] && m_stall < CMAX) m_stall++;
    if (e[5] && m_flush < CMAX) m_flush++;
  endtask

  // called at posedge+1: check before the next edge, advance model, step one clock
  task automatic tick(input string tag);
    #3;
    check_now(tag);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_now(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drive(input bit mr, input logic [4:0] rd, input logic [4:0] r1,
                       input logic [4:0] r2, input bit u1, input bit u2,
                       input bit br, input bit ma, input bit rdy);
    bus.MemRead_ex = mr;  bus.rdAddr_ex = rd;
    bus.rs1Addr_id = r1;  bus.rs2Addr_id = r2;
    bus.rs1Used_id = u1;  bus.rs2Used_id = u2;
    bus.BranchTaken_ex = br;
    bus.MemAccess_mem = ma; bus.MemReady_mem = rdy;
  endtask

  initial begin
    int burst;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    check_now("reset_state");
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick("idle");

    drive(1, 5, 5, 0, 1, 0, 0, 0, 0);  tick("load_use");
    drive(0, 5, 5, 0, 1, 0, 0, 0, 0);  tick("after_bubble");
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0);  tick("rd_zero");
    drive(1, 7, 1, 7, 0, 1, 0, 0, 0);  tick("rs2_hit");
    drive(1, 7, 1, 7, 0, 0, 0, 0, 0);  tick("rs2_unused");
    drive(1, 5, 5, 0, 1, 0, 1, 0, 0);  tick("branch_over_hit");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  tick("post_branch");

    async_reset("reset_before_wait");
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick("mem_wait");
    bus.MemReady_mem = 1'b1;
    tests++;
    assert (bus.StallCnt === CW'(PERF ? 3 : 0)) else begin
      fails++;
      $error("FAIL stall_cnt_3 observed=%0d expected=%0d", bus.StallCnt, PERF ? 3 : 0);
    end
    tick("mem_ready");
    bus.MemAccess_mem = 1'b0;         tick("wait_done");

    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    tick("freeze_over_branch_1");
    tick("freeze_over_branch_2");
    bus.MemReady_mem = 1'b1;          tick("branch_after_freeze");
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0); tick("rewait_1");
    bus.MemReady_mem = 1'b1;          tick("rewait_ready");
    bus.MemReady_mem = 1'b0;          tick("rewait_again");
    bus.MemAccess_mem = 1'b0;         tick("rewait_done");

    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < TO - 1; i++) tick("timeout_run");
    tests++;
    assert (bus.MemErr === 1'b0) else begin
      fails++;
      $error("FAIL timeout_early observed=%b expected=0", bus.MemErr);
    end
    tick("timeout_last");
    tests++;
    assert (bus.MemErr === 1'b1) else begin
      fails++;
      $error("FAIL timeout_hit observed=%b expected=1", bus.MemErr);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) tick("err_frozen");
    async_reset("reset_from_err");

    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick("midwait_1");
    tick("midwait_2");
    bus.MemAccess_mem = 1'b0;
    async_reset("reset_mid_wait");
    bus.MemAccess_mem = 1'b1;
    for (int i = 0; i < TO - 1; i++) tick("after_reset_wait");
    bus.MemReady_mem = 1'b1;          tick("after_reset_ready");

    burst = 0;
    for (int i = 0; i < 500; i++) begin
      if (m_err && ($urandom_range(0, 3) == 0)) async_reset("rand_reset");
      if (i % 90 == 45) burst = $urandom_range(12, 18);
      drive($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 1), ($urandom_range(0, 2) != 0));
      if (burst > 0) begin
        bus.MemAccess_mem = 1'b1;
        bus.MemReady_mem  = 1'b0;
        burst--;
      end
      tick("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
